// File: rtl/activation_loader_pkg.sv
// Shared accelerator constants: tile geometry, default widths and loader state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package activation_loader_pkg;

  localparam int ACT_WIDTH  = 7;   // bits per activation value
  localparam int MEM_DEPTH  = 64;  // activations per tile
  localparam int CAL_CYCLES = 8;   // cycles Cal is held per tile
  localparam int TILE_DIM   = 8;   // tile is TILE_DIM x TILE_DIM
  localparam int TILE_BITS  = $clog2(TILE_DIM);
  localparam int CAL_CNT_W  = 4;   // compute-phase counter width

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WAIT = 3'd2,
    ST_CAL  = 3'd3,
    ST_DONE = 3'd4
  } ld_state_e;

endpackage

// File: rtl/activation_loader_if.sv
// Activation stream bundle: value plus valid/ready handshake.
// Latency: n/a (wires only).
// Backpressure: source holds Act_in while Act_in_valid && !Act_in_ready.
interface activation_loader_if #(
  parameter int W = activation_loader_pkg::ACT_WIDTH
) ();

  logic [W-1:0] Act_in;
  logic         Act_in_valid;
  logic         Act_in_ready;

  modport master (
    output Act_in,
    output Act_in_valid,
    input  Act_in_ready
  );

  modport slave (
    input  Act_in,
    input  Act_in_valid,
    output Act_in_ready
  );

endinterface

// File: rtl/activation_loader_act_addr_gen.sv
// Maps the stream element counter to an activation-memory address (row- or column-major).
// Latency: combinational.
// Backpressure: none.
module act_addr_gen #(
  parameter int AW = 6
) (
  input  logic [AW-1:0] cnt,
  input  logic          order,
  output logic [AW-1:0] addr
);
  import activation_loader_pkg::*;

  // Column-major stream: swap row and column fields so element i lands at (i%8)*8 + i/8.
  always_comb begin
    addr = cnt;
    if (order) begin
      addr = {cnt[TILE_BITS-1:0], cnt[AW-1:TILE_BITS]};
    end
  end

endmodule

// File: rtl/activation_loader.sv
// Loads one 8x8 activation tile into memory, waits for weights, then runs the compute phase.
// Latency: data/address registered one cycle after each transfer; load_mem_done one cycle after the last write.
// Backpressure: Act_in_ready high only while loading; stream stalls freely via Act_in_valid.
module activation_loader #(
  parameter int ACT_WIDTH  = activation_loader_pkg::ACT_WIDTH,
  parameter int MEM_DEPTH  = activation_loader_pkg::MEM_DEPTH,
  parameter int CAL_CYCLES = activation_loader_pkg::CAL_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          Start,
  input  logic                          Act_Order,
  activation_loader_if.slave            act_s,
  input  logic                          Weight_Ready,
  output logic [ACT_WIDTH-1:0]          Activation,
  output logic [$clog2(MEM_DEPTH)-1:0]  Activation_Mem_Address_in,
  output logic                          load_mem_done,
  output logic                          Cal,
  output logic                          Tile_done
);
  import activation_loader_pkg::*;

  localparam int ADDR_W = $clog2(MEM_DEPTH);

  ld_state_e              state_q, state_d;
  logic [ADDR_W-1:0]      cnt_q, cnt_d;
  logic                   order_q, order_d;
  logic [ACT_WIDTH-1:0]   act_q, act_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   done_q, done_d;
  logic [CAL_CNT_W-1:0]   cal_cnt_q, cal_cnt_d;
  logic [ADDR_W-1:0]      gen_addr;
  logic                   ready;
  logic                   cal;
  logic                   tile_done;

  act_addr_gen #(
    .AW (ADDR_W)
  ) u_addr_gen (
    .cnt   (cnt_q),
    .order (order_q),
    .addr  (gen_addr)
  );

  // Next-state, datapath updates and state-decoded outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    order_d   = order_q;
    act_d     = act_q;
    addr_d    = addr_q;
    done_d    = done_q;
    cal_cnt_d = cal_cnt_q;
    ready     = 1'b0;
    cal       = 1'b0;
    tile_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          order_d = Act_Order;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ready = 1'b1;
        if (act_s.Act_in_valid) begin
          act_d  = act_s.Act_in;
          addr_d = gen_addr;
          cnt_d  = cnt_q + 1'b1;  // wraps to 0 after the last element
          if (cnt_q == ADDR_W'(MEM_DEPTH - 1)) begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // First WAIT cycle still presents the last write; done rises after it.
        done_d = 1'b1;
        if (done_q && Weight_Ready) begin
          cal_cnt_d = '0;
          state_d   = ST_CAL;
        end
      end
      ST_CAL: begin
        cal       = 1'b1;
        cal_cnt_d = cal_cnt_q + 1'b1;
        if (cal_cnt_q == CAL_CNT_W'(CAL_CYCLES - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        tile_done = 1'b1;
        done_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any tile in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      order_q   <= 1'b0;
      act_q     <= '0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      cal_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      order_q   <= order_d;
      act_q     <= act_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
      cal_cnt_q <= cal_cnt_d;
    end
  end

  assign act_s.Act_in_ready        = ready;
  assign Activation                = act_q;
  assign Activation_Mem_Address_in = addr_q;
  assign load_mem_done             = done_q;
  assign Cal                       = cal;
  assign Tile_done                 = tile_done;

endmodule

// File: doc/activation_loader.md
ACTIVATION_LOADER -- requirements
Module: activation_loader

Interface
REQ-001 The block SHALL expose parameter ACT_WIDTH, default 7, bit width of one activation value.
REQ-002 The block SHALL expose parameter MEM_DEPTH, default 64, activations per tile (8 rows x 8 columns).
REQ-003 The block SHALL expose parameter CAL_CYCLES, default 8, number of cycles Cal is held high per tile.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (asynchronous active-high reset).
REQ-005 The block SHALL have Start input 1, a one-cycle pulse that begins a tile load.
REQ-006 The block SHALL have Act_Order input 1, sampled at Start: 0 = row-major stream, 1 = column-major stream.
REQ-007 The block SHALL have Act_in input ACT_WIDTH, the streamed activation value.
REQ-008 The block SHALL have Act_in_valid input 1, the stream valid signal.
REQ-009 The block SHALL have Act_in_ready output 1, the stream ready signal.
REQ-010 The block SHALL have Weight_Ready input 1, which is high when the weight and compensation load is complete.
REQ-011 The block SHALL have Activation output ACT_WIDTH, the registered write data for the activation memory.
REQ-012 The block SHALL have Activation_Mem_Address_in output 6, the registered write address.
REQ-013 The block SHALL have load_mem_done output 1, high from tile-complete until the tile is retired.
REQ-014 The block SHALL have Cal output 1, the compute-phase enable for the activation memory.
REQ-015 The block SHALL have Tile_done output 1, a one-cycle pulse at the end of the compute phase.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, WAIT, CAL and DONE.
REQ-017 In IDLE, Start SHALL latch Act_Order, clear the 6-bit write counter and enter LOAD; Start is ignored in every other state.
REQ-018 Act_in_ready SHALL be high only in LOAD; an element transfers on Act_in_valid && Act_in_ready.
REQ-019 On each transfer, Activation SHALL register Act_in and Activation_Mem_Address_in SHALL register the counter value if order = 0, or {cnt[2:0],cnt[5:3]} if order = 1; both are visible one cycle after the transfer.
REQ-020 Between transfers, Activation and Activation_Mem_Address_in SHALL hold their last values, because the memory writes every cycle while load_mem_done = 0 and a held pair is an idempotent rewrite.
REQ-021 The counter SHALL increment per transfer; on the transfer with cnt = 63 the FSM SHALL enter WAIT and the counter SHALL wrap to 0.
REQ-022 load_mem_done SHALL rise in the cycle after the last write data/address is presented, so the 64th write lands before the memory stops writing.
REQ-023 WAIT SHALL last at least one full cycle with load_mem_done = 1 and Cal = 0 (memory row index clears), then go to CAL on Weight_Ready = 1.
REQ-024 Weight_Ready already high at the last transfer SHALL still incur exactly one WAIT cycle.
REQ-025 In CAL, Cal SHALL be high for exactly CAL_CYCLES consecutive cycles, counted by a 4-bit counter, then the FSM SHALL enter DONE.
REQ-026 DONE SHALL last one cycle with Tile_done = 1, Cal = 0 and load_mem_done = 1, then return to IDLE with load_mem_done = 0.
REQ-027 Act_in_valid outside LOAD SHALL be ignored and SHALL never change any register.

Reset
REQ-028 On rst, the block SHALL set state IDLE, counters 0, order 0, Activation 0, Activation_Mem_Address_in 0, Act_in_ready 0, load_mem_done 0, Cal 0 and Tile_done 0.
REQ-029 rst asserted mid-LOAD or mid-CAL SHALL abandon the tile immediately; no Tile_done pulse SHALL follow.

Structure
REQ-030 The state encoding, ACT_WIDTH, MEM_DEPTH, CAL_CYCLES and tile dimension 8 SHALL reside in the shared accelerator package.
REQ-031 Address generation SHALL be a sub-module, act_addr_gen (counter, order -> address), combinational; the FSM and registers stay in activation_loader.

Verification
REQ-032 The bench SHALL cover: Start, order 0, 64 back-to-back values v = i -> address i carries value i, load_mem_done rises the cycle after address 63, Act_in_ready falls.
REQ-033 The bench SHALL cover: order 1, values i streamed -> element i written to address (i%8)*8 + i/8, e.g. i = 9 -> address 9, i = 10 -> address 17.
REQ-034 The bench SHALL cover: valid toggled 1-0-1 with 3-cycle gaps -> data/address hold during gaps; 64 writes total; no duplicate addresses with differing data.
REQ-035 The bench SHALL cover: Weight_Ready held high throughout -> exactly 1 WAIT cycle, Cal high 8 cycles, Tile_done 1 cycle, then load_mem_done = 0.
REQ-036 The bench SHALL cover: Start pulsed during LOAD and during CAL -> no effect; Act_in_valid pulsed in WAIT -> no register change.
REQ-037 The bench SHALL cover: rst after 20 transfers -> all outputs 0 next edge, no Tile_done; a fresh Start reloads from address 0.
